sd_spi_byte_ctrl: RTL and testbench

//   SPI-mode byte-transfer controller for the SD card link (SPI mode 0, MSB first).
//   - Times SCLK half-periods, shifts one byte out on MOSI and captures one byte from MISO.
//   - Selects slow (init, ~400 kHz) or fast divide ratios and owns the chip select.
//   - Sits between the SD command/data sequencer (valid/ready byte stream) and the card pins.

---
 rtl/sd_spi_pkg.sv | 16 +
 rtl/sd_spi_half_timer.sv | 31 +++
 rtl/sd_spi_byte_ctrl.sv | 139 +++++++++++++
 tb/tb_sd_spi_byte_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD card SPI byte controller.
package sd_spi_pkg;

  localparam int DIV_W     = 8;
  localparam int BIT_CNT_W = 3;

  localparam logic MOSI_IDLE = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_e;

endpackage

// File: rtl/sd_spi_half_timer.sv
// Loadable half-period counter: tick fires when the count reaches div, then restarts at zero.
module sd_spi_half_timer
  import sd_spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi_byte_ctrl.sv
// SPI mode-0 byte transfer controller for the SD card link (MSB first, owns cs_n).
// Optional build macro SD_SPI_LOOPBACK_EN adds loop_en to capture from mosi instead of miso.
module sd_spi_byte_ctrl
  import sd_spi_pkg::*;
#(
  parameter logic [DIV_W-1:0] INIT_DIV = 8'd124,
  parameter logic [DIV_W-1:0] FAST_DIV = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fast,
  input  logic       cs_req,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
`ifdef SD_SPI_LOOPBACK_EN
  input  logic       loop_en,
`endif
  output logic       cs_n
);

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]             tx_sh_q, tx_sh_d;
  logic [7:0]             rx_sh_q, rx_sh_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_n_q, cs_n_d;
  logic                   tick;
  logic                   cap_bit;

`ifdef SD_SPI_LOOPBACK_EN
  assign cap_bit = loop_en ? mosi_q : miso;
`else
  assign cap_bit = miso;
`endif

  // Counter is held at zero while idle so every byte starts with a full half-period.
  sd_spi_half_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .div  (div_q),
    .tick (tick)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    unique case (state_q)
      IDLE: begin
        cs_n_d = ~cs_req;
        if (tx_valid) begin
          tx_sh_d   = tx_data[6:0];
          mosi_d    = tx_data[7];
          div_d     = fast ? FAST_DIV : INIT_DIV;
          bit_cnt_d = '0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sclk_d  = ~SCLK_IDLE;
          rx_sh_d = {rx_sh_q[6:0], cap_bit};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d = SCLK_IDLE;
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            mosi_d     = MOSI_IDLE;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            mosi_d    = tx_sh_q[6];
            tx_sh_d   = {tx_sh_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            state_d   = LOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= MOSI_IDLE;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_byte_ctrl.sv
// Randomised scoreboard bench for sd_spi_byte_ctrl: a card model feeds miso, a monitor checks rx bytes and timing.
module tb_sd_spi_byte_ctrl;

  localparam logic [7:0] INIT_DIV = 8'd124;
  localparam logic [7:0] FAST_DIV = 8'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fast = 1'b1;
  logic       cs_req = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso = 1'b1;
  logic       cs_n;
`ifdef SD_SPI_LOOPBACK_EN
  logic       loop_en = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] card_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // card model state
  logic [7:0] cur_tx = 8'h00;
  logic [7:0] cur_card = 8'h00;
  int         cur_div = 0;
  int         rise_n = 8;
  int         last_rise = 0;
  int         hi_run = 0;
  logic       sclk_prev = 1'b0;

  sd_spi_byte_ctrl #(
    .INIT_DIV (INIT_DIV),
    .FAST_DIV (FAST_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fast     (fast),
    .cs_req   (cs_req),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
`ifdef SD_SPI_LOOPBACK_EN
    .loop_en  (loop_en),
`endif
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Card model: detects accepts, drives miso MSB first, checks mosi and sclk timing.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      rise_n    = 8;
      sclk_prev = 1'b0;
      hi_run    = 0;
    end else begin
      if (sclk && !sclk_prev) begin
        if (rise_n < 8) begin
          chk("mosi_bit", int'(mosi), int'(cur_tx[7-rise_n]));
          if (rise_n > 0) chk("sclk_period", cyc - last_rise, 2 * (cur_div + 1));
          last_rise = cyc;
          rise_n++;
          if (rise_n < 8) miso = cur_card[7-rise_n];
        end else begin
          chk("sclk_stray_rise", 1, 0);
        end
      end
      if (!sclk && sclk_prev) chk("sclk_high_len", hi_run, cur_div + 1);
      hi_run = sclk ? hi_run + 1 : 0;
      if (tx_valid && tx_ready) begin
        exp_t e;
        cur_tx   = tx_data;
        cur_div  = fast ? int'(FAST_DIV) : int'(INIT_DIV);
        cur_card = (card_q.size() > 0) ? card_q.pop_front() : 8'($urandom);
        e.data   = cur_card;
`ifdef SD_SPI_LOOPBACK_EN
        if (loop_en) e.data = cur_tx;
`endif
        e.t = cyc + 1 + 16 * (cur_div + 1);
        exp_q.push_back(e);
        rise_n = 0;
        miso   = cur_card[7];
      end
      sclk_prev = sclk;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("rx_unexpected", int'(rx_data), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", int'(rx_data), int'(e.data));
        chk("rx_latency_cycle", cyc, e.t);
      end
    end
  end

  task automatic send(input logic [7:0] tx, input logic [7:0] card, input logic f);
    int n = 0;
    while (!tx_ready && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (!tx_ready) chk("send_wait_ready", 0, 1);
    card_q.push_back(card);
    fast     = f;
    tx_data  = tx;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || exp_q.size() > 0) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (busy || exp_q.size() > 0) chk("wait_done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic sp;
    // Reset and idle values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 1);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);

    // Fast byte with chip select; cs_req change applies on the accept edge
    cs_req = 1'b1;
    send(8'hA5, 8'h3C, 1'b1);
    chk("cs_n_on_accept", int'(cs_n), 0);
    chk("busy_after_accept", int'(busy), 1);
    wait_done();

    // Slow divider
    send(8'hFF, 8'h96, 1'b0);
    wait_done();

    // Back-to-back with tx_valid held
    card_q.push_back(8'h5E);
    card_q.push_back(8'hE7);
    fast = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h81;
    n = 0;
    while (!rx_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_first_rx_valid", int'(rx_valid), 1);
    chk("b2b_ready_in_rx_valid", int'(tx_ready), 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("b2b_second_busy", int'(busy), 1);
    wait_done();

    // Reset after the third rising sclk
    send(8'h77, 8'h11, 1'b1);
    n = 0; sp = sclk;
    while (n < 3) begin
      @(posedge clk); #1;
      if (sclk && !sp) n++;
      sp = sclk;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_mosi", int'(mosi), 1);
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_valid", int'(rx_valid), 0);
    chk("abort_rx_data", int'(rx_data), 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    send(8'h5A, 8'hC9, 1'b1);
    wait_done();

    // cs_req dropped mid-byte
    cs_req = 1'b1;
    @(posedge clk); #1;
    send(8'h96, 8'h42, 1'b1);
    repeat (10) @(posedge clk);
    #1 cs_req = 1'b0;
    chk("cs_hold_busy", int'(cs_n), 0);
    n = 0;
    while (!rx_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("cs_rx_valid_seen", int'(rx_valid), 1);
    chk("cs_hold_rx_valid", int'(cs_n), 0);
    @(posedge clk); #1;
    chk("cs_release", int'(cs_n), 1);
    wait_done();

`ifdef SD_SPI_LOOPBACK_EN
    loop_en = 1'b1;
    send(8'hC3, 8'h00, 1'b1);
    wait_done();
    loop_en = 1'b0;
`endif

    // Randomised transfers
    for (int i = 0; i < 16; i++) begin
      cs_req = 1'($urandom);
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 1) == 1) wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
